general: RTL and testbench



---
 rtl/general.sv | 85 ++++++++
 tb/tb_general.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/general.sv
// rtl/general.sv - sequential 8x8 signed radix-2 Booth multiplier; GENERAL_OUTPUT_GATE_EN gates Producto to DONE only
module general (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  DP_B,
  input  logic [7:0]  DP_Q,
  output logic [2:0]  ready,
  output logic [16:0] Producto
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOAD  = 3'b001,
    S_EVAL  = 3'b010,
    S_SHIFT = 3'b011,
    S_DONE  = 3'b100
  } state_t;

  state_t      r_state;
  logic [8:0]  r_a;
  logic [7:0]  r_m;
  logic [7:0]  r_q;
  logic        r_q_1;
  logic [3:0]  r_count;

  // A is one bit wider than M so that M = -128 negates without overflow
  logic [8:0]  w_m_ext;
  logic [8:0]  w_a_add;
  logic [8:0]  w_a_sub;
  logic [3:0]  w_count_next;
  logic [16:0] w_product;

  assign w_m_ext      = {r_m[7], r_m};
  assign w_a_add      = r_a + w_m_ext;
  assign w_a_sub      = r_a - w_m_ext;
  assign w_count_next = r_count - 4'd1;
  assign w_product    = {r_a[7:0], r_q, r_q_1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q_1   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_LOAD;
        S_LOAD: begin
          r_m     <= DP_B;
          r_q     <= DP_Q;
          r_a     <= '0;
          r_q_1   <= 1'b0;
          r_count <= 4'd8;
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          case ({r_q[0], r_q_1})
            2'b10:   r_a <= w_a_sub;
            2'b01:   r_a <= w_a_add;
            default: r_a <= r_a;
          endcase
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_a, r_q, r_q_1} <= {r_a[8], r_a, r_q};
          r_count <= w_count_next;
          r_state <= (w_count_next != 4'd0) ? S_EVAL : S_DONE;
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready = r_state;

`ifdef GENERAL_OUTPUT_GATE_EN
  assign Producto = (r_state == S_DONE) ? w_product : 17'd0;
`else
  assign Producto = w_product;
`endif

endmodule

// File: tb/tb_general.sv
// tb/tb_general.sv - scoreboard bench for the Booth multiplier general
module tb_general;

  logic        clk;
  logic        rst;
  logic [7:0]  DP_B;
  logic [7:0]  DP_Q;
  logic [2:0]  ready;
  logic [16:0] Producto;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];

  general dut (
    .clk      (clk),
    .rst      (rst),
    .DP_B     (DP_B),
    .DP_Q     (DP_Q),
    .ready    (ready),
    .Producto (Producto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [7:0] b, input logic [7:0] q);
    logic signed [7:0] sb;
    logic signed [7:0] sq;
    int p;
    sb = b;
    sq = q;
    p  = sb * sq;
    return {p[15:0], q[7]};
  endfunction

  // Holds reset, applies operands, queues the expected result, releases reset off-edge.
  task automatic start_op(input logic [7:0] b, input logic [7:0] q);
    rst  = 1'b0;
    DP_B = b;
    DP_Q = q;
    exp_q.push_back(model(b, q));
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Returns the edge count at which DONE appeared, or 0 when the budget expired.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (ready == 3'b100) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst  = 1'b0;
    DP_B = 8'h55;
    DP_Q = 8'h66;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=000", ready);
    end
    n_checks++;
    if (Producto !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_producto got=%h exp=00000", Producto);
    end
  endtask

  task automatic test_products;
    logic [7:0] tb_b[12];
    logic [7:0] tb_q[12];
    logic [16:0] exp;
    int edges;
    tb_b = '{8'd23, 8'hFD, 8'd7, 8'h80, 8'h7F, 8'h80, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
    tb_q = '{8'd17, 8'd5,  8'hFE, 8'h80, 8'h80, 8'h7F, 8'hA5, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 8; i < 12; i++) begin
      tb_b[i] = 8'($urandom_range(0, 255));
      tb_q[i] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 12; i++) begin
      start_op(tb_b[i], tb_q[i]);
      wait_done(edges);
      exp = exp_q.pop_front();
      n_checks++;
      if (edges != 18) begin
        n_fail++;
        $display("FAIL latency_%0d got=%0d exp=18", i, edges);
      end
      n_checks++;
      if (Producto !== exp) begin
        n_fail++;
        $display("FAIL product_%0d b=%h q=%h got=%h exp=%h", i, tb_b[i], tb_q[i], Producto, exp);
      end
    end
  endtask

  task automatic test_state_walk;
    logic [2:0]  exp_state;
    logic [16:0] exp;
    start_op(8'hC4, 8'h39);
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk);
      #1;
      if (k == 1)       exp_state = 3'b001;
      else if (k <= 17) exp_state = (k % 2 == 0) ? 3'b010 : 3'b011;
      else              exp_state = 3'b100;
      n_checks++;
      if (ready !== exp_state) begin
        n_fail++;
        $display("FAIL walk_edge_%0d got=%b exp=%b", k, ready, exp_state);
      end
      if (k == 3) begin
        DP_B = 8'h11;
        DP_Q = 8'h22;
      end
`ifdef GENERAL_OUTPUT_GATE_EN
      if (k < 18) begin
        n_checks++;
        if (Producto !== 17'd0) begin
          n_fail++;
          $display("FAIL gate_edge_%0d got=%h exp=00000", k, Producto);
        end
      end
`else
      if (k == 2) begin
        n_checks++;
        if (Producto !== {8'h00, 8'h39, 1'b0}) begin
          n_fail++;
          $display("FAIL load_visible got=%h exp=%h", Producto, {8'h00, 8'h39, 1'b0});
        end
      end
`endif
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (Producto !== exp) begin
      n_fail++;
      $display("FAIL walk_product got=%h exp=%h", Producto, exp);
    end
  endtask

  task automatic test_abort;
    logic [16:0] exp;
    int edges;
    start_op(8'h5A, 8'hB3);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    void'(exp_q.pop_front());
    #1;
    n_checks++;
    if (ready !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_ready got=%b exp=000", ready);
    end
    n_checks++;
    if (Producto !== 17'd0) begin
      n_fail++;
      $display("FAIL abort_producto got=%h exp=00000", Producto);
    end
    start_op(8'hE9, 8'h4D);
    wait_done(edges);
    exp = exp_q.pop_front();
    n_checks++;
    if (edges != 18) begin
      n_fail++;
      $display("FAIL abort_restart_latency got=%0d exp=18", edges);
    end
    n_checks++;
    if (Producto !== exp) begin
      n_fail++;
      $display("FAIL abort_restart_product got=%h exp=%h", Producto, exp);
    end
  endtask

  initial begin
    rst  = 1'b0;
    DP_B = '0;
    DP_Q = '0;
    test_reset();
    test_products();
    test_state_walk();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
